mod503_chunk_reduce_seq: RTL and testbench

- Sequential residue engine: reduces a wide unsigned operand modulo 503 by walking it in 6-bit chunks, least-significant first.
- For each chunk it forms the weighted residue (chunk * 2^(6*k)) mod 503, which is the job of the existing 6-input/9-output residue LUTs, and accumulates the results mod 503.
- Sits between operand producers and the modular-arithmetic datapath. One shared weight-LUT path replaces a full parallel LUT tree.

---
 rtl/mod503_pkg.sv | 37 +++
 rtl/mod503_weight_lut.sv | 34 +++
 rtl/mod503_chunk_reduce_seq.sv | 123 ++++++++++++
 tb/tb_mod503_chunk_reduce_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mod503_pkg.sv
// mod503_pkg: shared constants, types and helpers for the mod-503 chunk residue engine.
// Rev 1.0
`default_nettype none

package mod503_pkg;

  localparam int MOD     = 503;
  localparam int RES_W   = 9;
  localparam int CHUNK_W = 6;

  typedef logic [RES_W-1:0]   res_t;
  typedef logic [CHUNK_W-1:0] chunk_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Both operands are below MOD, so one conditional subtract brings the sum back in range.
  function automatic res_t mod_add(input res_t a, input res_t b);
    logic [RES_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (RES_W+1)'(MOD)) s = s - (RES_W+1)'(MOD);
    return s[RES_W-1:0];
  endfunction

  function automatic int weight_of(input int k);
    int r;
    r = 1;
    for (int j = 0; j < k; j++) r = (r * (1 << CHUNK_W)) % MOD;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod503_weight_lut.sv
// mod503_weight_lut: combinational (chunk * 2^(6k)) mod 503 for chunk position k.
// Rev 1.0
`default_nettype none

module mod503_weight_lut
  import mod503_pkg::*;
#(
  parameter int NCHUNK = 10,
  parameter int K_W    = 4
) (
  input  chunk_t         i_chunk,
  input  logic [K_W-1:0] i_k,
  output res_t           o_weight
);

  res_t w_table [NCHUNK];

  for (genvar g = 0; g < NCHUNK; g++) begin : g_pos
    localparam int c_WEIGHT = weight_of(g);
    logic [CHUNK_W+RES_W-1:0] w_prod;
    assign w_prod     = (CHUNK_W+RES_W)'(i_chunk) * (CHUNK_W+RES_W)'(c_WEIGHT);
    assign w_table[g] = res_t'(w_prod % (CHUNK_W+RES_W)'(MOD));
  end

  always_comb begin
    o_weight = '0;
    for (int j = 0; j < NCHUNK; j++) begin
      if (i_k == K_W'(j)) o_weight = w_table[j];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod503_chunk_reduce_seq.sv
// mod503_chunk_reduce_seq: reduces an OP_W-bit operand mod 503, one 6-bit chunk per cycle.
// Optional MOD503_ZERO_SKIP_EN ends the walk early once the remaining operand is zero. Rev 1.0
`default_nettype none

module mod503_chunk_reduce_seq
  import mod503_pkg::*;
#(
  parameter int OP_W = 60
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RES_W-1:0] out_res,
  output logic            busy
);

  localparam int NCHUNK = OP_W / CHUNK_W;
  localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t          r_state;
  logic [OP_W-1:0] r_shreg;
  logic [K_W-1:0]  r_k;
  res_t            r_acc;
  res_t            r_out_res;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  res_t            w_weight;
  res_t            w_acc_next;
  logic            w_last;

  mod503_weight_lut #(
    .NCHUNK (NCHUNK),
    .K_W    (K_W)
  ) u_lut (
    .i_chunk  (r_shreg[CHUNK_W-1:0]),
    .i_k      (r_k),
    .o_weight (w_weight)
  );

  assign w_acc_next = mod_add(r_acc, w_weight);

`ifdef MOD503_ZERO_SKIP_EN
  logic w_zero;
  assign w_zero = (r_shreg == '0);
  assign w_last = (r_k == K_W'(NCHUNK-1)) || ((r_shreg >> CHUNK_W) == '0);
`else
  assign w_last = (r_k == K_W'(NCHUNK-1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_out_res   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_shreg    <= in_data;
            r_acc      <= '0;
            r_k        <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
`ifdef MOD503_ZERO_SKIP_EN
          if (w_zero) begin
            r_state     <= DONE;
            r_out_res   <= r_acc;
            r_out_valid <= 1'b1;
          end else
`endif
          begin
            r_acc   <= w_acc_next;
            r_shreg <= r_shreg >> CHUNK_W;
            r_k     <= r_k + 1'b1;
            // Result is latched separately so it survives the next operand's acc clear.
            if (w_last) begin
              r_state     <= DONE;
              r_out_res   <= w_acc_next;
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mod503_chunk_reduce_seq.sv
// tb_mod503_chunk_reduce_seq: directed and random checks of the mod-503 chunk reducer against arithmetic modulo.
// Rev 1.0
`default_nettype none

module tb_mod503_chunk_reduce_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_res;
  logic        busy;

  int n_checks;
  int n_fail;

  mod503_chunk_reduce_seq #(.OP_W(60)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [59:0] d);
    return {4'b0, d % 60'd503};
  endfunction

  function automatic int ref_lat(input logic [59:0] d);
    int h;
    h = 0;
`ifdef MOD503_ZERO_SKIP_EN
    for (int i = 0; i < 10; i++)
      if (((d >> (6*i)) & 60'h3f) != 60'h0) h = i + 1;
    if (h == 0) h = 1;
`else
    h = 10;
`endif
    return h;
  endfunction

  task automatic send_op(input logic [59:0] d, input int stall);
    int cyc;
    logic [8:0] held;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    check_eq("run_busy", busy, 1);
    check_eq("run_in_ready", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("latency", cyc, ref_lat(d));
    check_eq("residue", out_res, ref_res(d));
    held = out_res;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check_eq("stall_res", out_res, held);
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("post_hs_valid", out_valid, 0);
    check_eq("post_hs_in_ready", in_ready, 1);
    check_eq("post_hs_busy", busy, 0);
    check_eq("post_hs_res_kept", out_res, held);
  endtask

  initial begin
    int cnt;
    int viol;
    logic [59:0] d;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_in_ready", in_ready, 1);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_out_res", out_res, 0);
    check_eq("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send_op(60'd1, 0);
    send_op(60'd503, 0);
    send_op(60'd512, 1);
    send_op({60{1'b1}}, 2);
    send_op(60'd7, 20);
    send_op(60'd0, 0);
    send_op(60'd5, 0);
    send_op(60'd1 << 59, 0);

    // Reset in the middle of a run discards the partial result.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 60'd1 << 59;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrun_rst_valid", out_valid, 0);
    check_eq("midrun_rst_in_ready", in_ready, 1);
    check_eq("midrun_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check_eq("midrun_rst_no_valid", cnt, 0);
    send_op(60'd1006, 0);

    // Back-to-back with in_valid held: second accept only after first handshake.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 60'd7;
    @(posedge clk); #1;
    in_data = 60'd510;
    cnt = 0;
    viol = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      if (in_ready) viol++;
      cnt++;
    end
    check_eq("b2b_first_res", out_res, 7);
    check_eq("b2b_no_ready", viol, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("b2b_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("b2b_second_accept", busy, 1);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_eq("b2b_second_lat", cnt, ref_lat(60'd510));
    check_eq("b2b_second_res", out_res, 7);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("b2b_done", out_valid, 0);

    for (int i = 0; i < 2000; i++) begin
      d = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) d = d >> $urandom_range(0, 59);
      send_op(d, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
